// File: rtl/dma_priority_resolver.sv
// DMA request/priority stage: conditions DREQ, raises HRQ, grants one channel on HLDA.
// Optional software request register is enabled by defining DMA_SW_REQUEST_EN.
module dma_priority_resolver #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic              HLDA,
  input  logic [NUM_CH-1:0] maskReg,
  input  logic              priorityType,
  input  logic              dreqSenseActiveLow,
  input  logic              controllerDisable,
  input  logic              serviceDone,
`ifdef DMA_SW_REQUEST_EN
  input  logic [NUM_CH-1:0] swReq,
  input  logic              swReqSet,
`endif
  output logic              HRQ,
  output logic [NUM_CH-1:0] DACK,
  output logic [CH_W-1:0]   activeChannel,
  output logic              channelValid
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_HLDA, S_SERVICE} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_hrq, w_hrq_nxt;
  logic [NUM_CH-1:0]   r_dack, w_dack_nxt;
  logic [CH_W-1:0]     r_ch, w_ch_nxt;
  logic                r_vld, w_vld_nxt;
  logic [CH_W-1:0]     r_lowpri, w_lowpri_nxt;
  logic [NUM_CH-1:0]   w_eff;
  logic [CH_W-1:0]     w_winner;
  logic [CH_W-1:0]     w_idx;
  logic                w_found;
  logic                w_done;

`ifdef DMA_SW_REQUEST_EN
  logic [NUM_CH-1:0]   r_swreq, w_swreq_nxt, w_sw;

  // The completing channel's software bit is dropped before re-evaluation,
  // so a finished software request does not immediately re-raise HRQ.
  always_comb begin
    w_sw = r_swreq;
    if (r_state == S_SERVICE && serviceDone) w_sw = r_swreq & ~r_dack;
    w_swreq_nxt = w_sw;
    if (|swReq) w_swreq_nxt = swReqSet ? (w_sw | swReq) : (w_sw & ~swReq);
  end

  always_ff @(posedge CLK) begin
    if (RESET) r_swreq <= '0;
    else       r_swreq <= w_swreq_nxt;
  end
`endif

  always_comb begin
    w_eff = (DREQ ^ {NUM_CH{dreqSenseActiveLow}}) & ~maskReg;
`ifdef DMA_SW_REQUEST_EN
    w_eff = w_eff | w_sw;
`endif
    if (controllerDisable) w_eff = '0;
  end

  // Rotating search starts just after the last-serviced channel and wraps.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_idx = priorityType ? (r_lowpri + CH_W'(k + 1)) : CH_W'(k);
      if (!w_found && w_eff[w_idx]) begin
        w_winner = w_idx;
        w_found  = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_hrq_nxt    = r_hrq;
    w_dack_nxt   = r_dack;
    w_ch_nxt     = r_ch;
    w_vld_nxt    = r_vld;
    w_lowpri_nxt = r_lowpri;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_eff) begin
          w_hrq_nxt   = 1'b1;
          w_state_nxt = S_WAIT_HLDA;
        end
      end
      S_WAIT_HLDA: begin
        if (w_eff == '0) begin
          w_hrq_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end else if (HLDA) begin
          w_dack_nxt  = NUM_CH'(1) << w_winner;
          w_ch_nxt    = w_winner;
          w_vld_nxt   = 1'b1;
          w_state_nxt = S_SERVICE;
        end
      end
      S_SERVICE: begin
        if (serviceDone) begin
          w_done       = 1'b1;
          w_dack_nxt   = '0;
          w_vld_nxt    = 1'b0;
          w_lowpri_nxt = r_ch;
          if (HLDA && (w_eff != '0)) begin
            w_hrq_nxt   = 1'b1;
            w_state_nxt = S_WAIT_HLDA;
          end else begin
            w_hrq_nxt   = 1'b0;
            w_state_nxt = S_IDLE;
          end
        end else if (!HLDA) begin
          // Abort: grant dropped without touching the rotation pointer.
          w_dack_nxt  = '0;
          w_vld_nxt   = 1'b0;
          w_hrq_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_hrq_nxt   = 1'b0;
        w_dack_nxt  = '0;
        w_vld_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= S_IDLE;
      r_hrq    <= 1'b0;
      r_dack   <= '0;
      r_ch     <= '0;
      r_vld    <= 1'b0;
      r_lowpri <= CH_W'(NUM_CH - 1);
    end else begin
      r_state  <= w_state_nxt;
      r_hrq    <= w_hrq_nxt;
      r_dack   <= w_dack_nxt;
      r_ch     <= w_ch_nxt;
      r_vld    <= w_vld_nxt;
      r_lowpri <= w_lowpri_nxt;
    end
  end

  assign HRQ           = r_hrq;
  assign DACK          = r_dack;
  assign activeChannel = r_ch;
  assign channelValid  = r_vld;

  logic w_unused;
  assign w_unused = w_done;

endmodule

// File: tb/tb_dma_priority_resolver.sv
// Self-checking bench for dma_priority_resolver: directed scenarios plus randomized
// traffic against a transaction-level reference model.
module tb_dma_priority_resolver;
  localparam int N = 4;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [N-1:0] DREQ;
  logic         HLDA;
  logic [N-1:0] maskReg;
  logic         priorityType;
  logic         dreqSenseActiveLow;
  logic         controllerDisable;
  logic         serviceDone;
  logic         HRQ;
  logic [N-1:0] DACK;
  logic [1:0]   activeChannel;
  logic         channelValid;
`ifdef DMA_SW_REQUEST_EN
  logic [N-1:0] swReq    = '0;
  logic         swReqSet = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  dma_priority_resolver #(.NUM_CH(N)) dut (
    .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .HLDA(HLDA), .maskReg(maskReg),
    .priorityType(priorityType), .dreqSenseActiveLow(dreqSenseActiveLow),
    .controllerDisable(controllerDisable), .serviceDone(serviceDone),
`ifdef DMA_SW_REQUEST_EN
    .swReq(swReq), .swReqSet(swReqSet),
`endif
    .HRQ(HRQ), .DACK(DACK), .activeChannel(activeChannel), .channelValid(channelValid)
  );

  always #5 CLK = ~CLK;

  // Reference model: tracks "is a request pending", "who holds the bus", and
  // the last channel that completed service.
  int m_phase;    // 0 no request raised, 1 HRQ up awaiting HLDA, 2 channel granted
  int m_owner;
  int m_last;
  logic m_hrq;

  function automatic int eff_bits(input logic [N-1:0] d, input logic [N-1:0] m,
                                  input logic lo, input logic dis);
    int r = 0;
    for (int c = 0; c < N; c++)
      if (!dis && !m[c] && ((d[c] == 1'b1) != lo)) r += (1 << c);
    return r;
  endfunction

  function automatic int pick(input int eff, input logic rot, input int last);
    for (int k = 1; k <= N; k++) begin
      int c = rot ? (last + k) % N : k - 1;
      if ((eff >> c) & 1) return c;
    end
    return 0;
  endfunction

  always @(posedge CLK) begin
    int e;
    e = eff_bits(DREQ, maskReg, dreqSenseActiveLow, controllerDisable);
    if (RESET) begin
      m_phase <= 0; m_owner <= 0; m_last <= N - 1; m_hrq <= 1'b0;
    end else if (m_phase == 0) begin
      if (e != 0) begin m_phase <= 1; m_hrq <= 1'b1; end
    end else if (m_phase == 1) begin
      if (e == 0) begin m_phase <= 0; m_hrq <= 1'b0; end
      else if (HLDA) begin m_phase <= 2; m_owner <= pick(e, priorityType, m_last); end
    end else begin
      if (serviceDone) begin
        m_last <= m_owner;
        if (HLDA && e != 0) m_phase <= 1;
        else begin m_phase <= 0; m_hrq <= 1'b0; end
      end else if (!HLDA) begin
        m_phase <= 0; m_hrq <= 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic clear_inputs();
    DREQ = '0; HLDA = 1'b0; maskReg = '0; serviceDone = 1'b0;
    dreqSenseActiveLow = 1'b0; controllerDisable = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1; step(); RESET = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs(); priorityType = 1'b0;
    do_reset();
    checks++;
    if ({HRQ, DACK, activeChannel, channelValid} !== 8'b0) begin
      errors++;
      $display("FAIL reset_outputs got hrq=%b dack=%b ch=%0d vld=%b want all 0",
               HRQ, DACK, activeChannel, channelValid);
    end
  endtask

  task automatic test_fixed_basic();
    clear_inputs(); priorityType = 1'b0; do_reset();
    DREQ = 4'b0011; step();
    checks++;
    if (HRQ !== 1'b1 || DACK !== 4'b0000) begin
      errors++; $display("FAIL fixed_hrq_latency got hrq=%b dack=%b want hrq=1 dack=0000", HRQ, DACK);
    end
    HLDA = 1'b1; step();
    checks++;
    if (DACK !== 4'b0001 || activeChannel !== 2'd0 || channelValid !== 1'b1) begin
      errors++; $display("FAIL fixed_grant got dack=%b ch=%0d vld=%b want 0001/0/1", DACK, activeChannel, channelValid);
    end
  endtask

  task automatic test_fixed_mask();
    clear_inputs(); priorityType = 1'b0; do_reset();
    DREQ = 4'b1110; HLDA = 1'b1; step(); step();
    checks++;
    if (DACK !== 4'b0010 || activeChannel !== 2'd1) begin
      errors++; $display("FAIL fixed_unmasked got dack=%b ch=%0d want 0010/1", DACK, activeChannel);
    end
    do_reset();
    maskReg = 4'b0010; step(); step();
    checks++;
    if (DACK !== 4'b0100 || activeChannel !== 2'd2) begin
      errors++; $display("FAIL fixed_masked got dack=%b ch=%0d want 0100/2", DACK, activeChannel);
    end
    // Active-low sense: only bit 2 is low, so only channel 2 requests.
    do_reset(); maskReg = '0; dreqSenseActiveLow = 1'b1; DREQ = 4'b1011;
    step(); step();
    checks++;
    if (DACK !== 4'b0100) begin
      errors++; $display("FAIL sense_low got dack=%b want 0100", DACK);
    end
  endtask

  task automatic test_rotating();
    logic [N-1:0] exp;
    clear_inputs(); priorityType = 1'b1; do_reset();
    DREQ = 4'b1111; HLDA = 1'b1; step(); step();
    for (int g = 0; g < 5; g++) begin
      exp = 4'b0001 << (g % N);
      checks++;
      if (DACK !== exp || HRQ !== 1'b1 || activeChannel !== 2'(g % N)) begin
        errors++; $display("FAIL rotate_grant%0d got dack=%b hrq=%b ch=%0d want dack=%b hrq=1", g, DACK, HRQ, activeChannel, exp);
      end
      if (g < 4) begin
        serviceDone = 1'b1; step(); serviceDone = 1'b0;
        checks++;
        if (DACK !== 4'b0000 || HRQ !== 1'b1 || channelValid !== 1'b0) begin
          errors++; $display("FAIL rotate_gap%0d got dack=%b hrq=%b vld=%b want 0000/1/0", g, DACK, HRQ, channelValid);
        end
        step();
      end
    end
  endtask

  task automatic test_abort();
    clear_inputs(); priorityType = 1'b1; do_reset();
    DREQ = 4'b0100; HLDA = 1'b1; step(); step();
    checks++;
    if (DACK !== 4'b0100) begin
      errors++; $display("FAIL abort_grant got dack=%b want 0100", DACK);
    end
    HLDA = 1'b0; step();
    checks++;
    if (DACK !== 4'b0000 || HRQ !== 1'b0 || channelValid !== 1'b0 || activeChannel !== 2'd2) begin
      errors++; $display("FAIL abort_release got dack=%b hrq=%b vld=%b ch=%0d want 0000/0/0/2", DACK, HRQ, channelValid, activeChannel);
    end
    // If abort had moved the pointer to 2, channel 3 would win here.
    DREQ = 4'b1100; HLDA = 1'b1; step(); step();
    checks++;
    if (DACK !== 4'b0100) begin
      errors++; $display("FAIL abort_regrant got dack=%b want 0100", DACK);
    end
  endtask

  task automatic test_withdraw();
    bit seen_dack = 0;
    clear_inputs(); priorityType = 1'b0; do_reset();
    DREQ = 4'b0001; step();
    checks++;
    if (HRQ !== 1'b1) begin
      errors++; $display("FAIL withdraw_hrq_up got %b want 1", HRQ);
    end
    DREQ = '0; step();
    checks++;
    if (HRQ !== 1'b0) begin
      errors++; $display("FAIL withdraw_hrq_down got %b want 0", HRQ);
    end
    HLDA = 1'b1;
    for (int i = 0; i < 4; i++) begin step(); if (DACK !== 4'b0000) seen_dack = 1; end
    checks++;
    if (seen_dack) begin
      errors++; $display("FAIL withdraw_no_dack got a grant want none");
    end
    controllerDisable = 1'b1; DREQ = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (HRQ !== 1'b0) begin
        errors++; $display("FAIL disable_hrq cycle %0d got %b want 0", i, HRQ);
      end
    end
  endtask

  task automatic test_reset_mid_service();
    clear_inputs(); priorityType = 1'b1; do_reset();
    DREQ = 4'b1000; HLDA = 1'b1; step(); step();
    checks++;
    if (DACK !== 4'b1000) begin
      errors++; $display("FAIL midrst_grant got dack=%b want 1000", DACK);
    end
    RESET = 1'b1; step(); RESET = 1'b0;
    checks++;
    if (HRQ !== 1'b0 || DACK !== 4'b0000 || channelValid !== 1'b0 || activeChannel !== 2'd0) begin
      errors++; $display("FAIL midrst_clear got hrq=%b dack=%b vld=%b ch=%0d want 0/0000/0/0", HRQ, DACK, channelValid, activeChannel);
    end
    DREQ = 4'b1111; step(); step();
    checks++;
    if (DACK !== 4'b0001) begin
      errors++; $display("FAIL midrst_regrant got dack=%b want 0001", DACK);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] exp_dack;
    clear_inputs(); priorityType = 1'b1; do_reset();
    for (int i = 0; i < 600; i++) begin
      RESET       = ($urandom_range(0, 79) == 0);
      DREQ        = N'($urandom);
      HLDA        = ($urandom_range(0, 3) != 0);
      serviceDone = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) maskReg = N'($urandom);
      if ($urandom_range(0, 31) == 0) priorityType = ~priorityType;
      if ($urandom_range(0, 31) == 0) dreqSenseActiveLow = ~dreqSenseActiveLow;
      controllerDisable = ($urandom_range(0, 19) == 0);
      step();
      exp_dack = (m_phase == 2) ? N'(1 << m_owner) : '0;
      checks++;
      if (HRQ !== m_hrq || DACK !== exp_dack || channelValid !== (m_phase == 2) ||
          activeChannel !== 2'(m_owner)) begin
        errors++;
        $display("FAIL random_cyc%0d got hrq=%b dack=%b ch=%0d vld=%b want hrq=%b dack=%b ch=%0d vld=%b",
                 i, HRQ, DACK, activeChannel, channelValid, m_hrq, exp_dack, m_owner, (m_phase == 2));
      end
    end
    RESET = 1'b0; serviceDone = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; priorityType = 1'b0;
    clear_inputs();
    test_reset();
    test_fixed_basic();
    test_fixed_mask();
    test_rotating();
    test_abort();
    test_withdraw();
    test_reset_mid_service();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
